pp_agg: RTL and testbench

Column aggregation stage directly downstream of the pp compute core. Consumes the core's per-row predicate bit and numeric result as a valid/ready stream, and accumulates pandas-style reductions over one column segment: masked count, masked sum, masked signed min/max and total row count. Segments are delimited by a last flag. One result record is presented on a valid/ready output per segment.

---
 rtl/pp_agg.sv | 135 +++++++++++++
 tb/tb_pp_agg.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_agg.sv
// rtl/pp_agg.sv - masked count/sum/min/max column aggregation over last-delimited segments
module pp_agg #(
    parameter  int NUM_SIZE = 32,
    parameter  int CNT_SIZE = 16,
    localparam int SUM_SIZE = NUM_SIZE + CNT_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mask,
    input  logic [NUM_SIZE-1:0] in_data,
    input  logic                in_last,
    output logic                agg_valid,
    input  logic                agg_ready,
    output logic [CNT_SIZE-1:0] agg_rows,
    output logic [CNT_SIZE-1:0] agg_count,
    output logic [SUM_SIZE-1:0] agg_sum,
    output logic [NUM_SIZE-1:0] agg_min,
    output logic [NUM_SIZE-1:0] agg_max,
    output logic                agg_empty,
    output logic                agg_sat
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;

    state_t              state;
    logic [CNT_SIZE-1:0] acc_rows;
    logic [CNT_SIZE-1:0] acc_count;
    logic [SUM_SIZE-1:0] acc_sum;
    logic [NUM_SIZE-1:0] acc_min;
    logic [NUM_SIZE-1:0] acc_max;
    logic                acc_sat;

    logic                row_full;
    logic                cnt_full;
    logic                take;
    logic [CNT_SIZE-1:0] nxt_rows;
    logic [CNT_SIZE-1:0] nxt_count;
    logic [SUM_SIZE-1:0] nxt_sum;
    logic [NUM_SIZE-1:0] nxt_min;
    logic [NUM_SIZE-1:0] nxt_max;
    logic                nxt_sat;
    logic [SUM_SIZE-1:0] data_ext;

    // Value the accumulators take if the current beat is accepted. Once the
    // selected count is pinned at its maximum, further selected rows are dropped
    // from sum/min/max so the record stays self-consistent.
    always_comb begin
        row_full  = (acc_rows == CNT_MAX);
        cnt_full  = (acc_count == CNT_MAX);
        take      = in_mask && !cnt_full;
        data_ext  = {{CNT_SIZE{in_data[NUM_SIZE-1]}}, in_data};
        nxt_rows  = row_full ? acc_rows : acc_rows + CNT_SIZE'(1);
        nxt_count = take ? acc_count + CNT_SIZE'(1) : acc_count;
        nxt_sum   = take ? acc_sum + data_ext : acc_sum;
        nxt_min   = acc_min;
        nxt_max   = acc_max;
        if (take) begin
            if (acc_count == '0 || $signed(in_data) < $signed(acc_min)) nxt_min = in_data;
            if (acc_count == '0 || $signed(in_data) > $signed(acc_max)) nxt_max = in_data;
        end
        nxt_sat   = acc_sat || row_full || (in_mask && cnt_full);
    end

    // Accumulators are cleared as the last beat is captured; nothing is accepted
    // in HOLD, so they are already zero when the handshake returns us to ACCUM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            agg_valid <= 1'b0;
            acc_rows  <= '0;
            acc_count <= '0;
            acc_sum   <= '0;
            acc_min   <= '0;
            acc_max   <= '0;
            acc_sat   <= 1'b0;
            agg_rows  <= '0;
            agg_count <= '0;
            agg_sum   <= '0;
            agg_min   <= '0;
            agg_max   <= '0;
            agg_empty <= 1'b1;
            agg_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        if (in_last) begin
                            agg_rows  <= nxt_rows;
                            agg_count <= nxt_count;
                            agg_sum   <= nxt_sum;
                            agg_min   <= nxt_min;
                            agg_max   <= nxt_max;
                            agg_empty <= (nxt_count == '0);
                            agg_sat   <= nxt_sat;
                            acc_rows  <= '0;
                            acc_count <= '0;
                            acc_sum   <= '0;
                            acc_min   <= '0;
                            acc_max   <= '0;
                            acc_sat   <= 1'b0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            agg_valid <= 1'b1;
                        end else begin
                            acc_rows  <= nxt_rows;
                            acc_count <= nxt_count;
                            acc_sum   <= nxt_sum;
                            acc_min   <= nxt_min;
                            acc_max   <= nxt_max;
                            acc_sat   <= nxt_sat;
                        end
                    end
                end
                HOLD: begin
                    if (agg_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        agg_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    agg_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_agg.sv
// tb/tb_pp_agg.sv - self-checking bench for pp_agg
module tb_pp_agg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0, in_mask = 1'b0, in_last = 1'b0, agg_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, agg_valid, agg_empty, agg_sat;
    logic [15:0] agg_rows, agg_count;
    logic [47:0] agg_sum;
    logic [31:0] agg_min, agg_max;

    logic        s_valid = 1'b0, s_mask = 1'b0, s_last = 1'b0, s_aready = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, s_avalid, s_empty, s_sat;
    logic [3:0]  s_rows, s_count;
    logic [35:0] s_sum;
    logic [31:0] s_min, s_max;

    pp_agg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_data(in_data), .in_last(in_last),
        .agg_valid(agg_valid), .agg_ready(agg_ready),
        .agg_rows(agg_rows), .agg_count(agg_count), .agg_sum(agg_sum),
        .agg_min(agg_min), .agg_max(agg_max), .agg_empty(agg_empty), .agg_sat(agg_sat)
    );

    pp_agg #(.NUM_SIZE(32), .CNT_SIZE(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_ready(s_ready), .in_mask(s_mask),
        .in_data(s_data), .in_last(s_last),
        .agg_valid(s_avalid), .agg_ready(s_aready),
        .agg_rows(s_rows), .agg_count(s_count), .agg_sum(s_sum),
        .agg_min(s_min), .agg_max(s_max), .agg_empty(s_empty), .agg_sat(s_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int d;
    } beat_t;

    typedef struct {
        longint rows, count, sum, mn, mx;
        bit     empty, sat;
    } rec_t;

    typedef struct {
        int     n;
        bit     m[4];
        int     d[4];
        longint rows, count, sum, mn, mx;
        bit     empty;
    } vec_t;

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t seg[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list the selected values, keep only the first cmax of them,
    // then reduce with plain arithmetic.
    function automatic rec_t model(input longint cmax);
        rec_t   r;
        longint sel[$];
        int     nsel = 0;
        r = '{0, 0, 0, 0, 0, 1'b1, 1'b0};
        foreach (seg[i]) if (seg[i].m) begin
            nsel++;
            if (nsel <= cmax) sel.push_back(longint'(seg[i].d));
        end
        foreach (sel[i]) begin
            r.sum += sel[i];
            if (i == 0 || sel[i] < r.mn) r.mn = sel[i];
            if (i == 0 || sel[i] > r.mx) r.mx = sel[i];
        end
        r.rows  = (seg.size() > cmax) ? cmax : seg.size();
        r.count = sel.size();
        r.empty = (sel.size() == 0);
        r.sat   = (seg.size() > cmax) || (nsel > cmax);
        return r;
    endfunction

    task automatic check_rec(input string tag, input rec_t e);
        check({tag, ".rows"},  agg_rows, e.rows);
        check({tag, ".count"}, agg_count, e.count);
        check({tag, ".sum"},   longint'($signed(agg_sum)), e.sum);
        check({tag, ".min"},   longint'($signed(agg_min)), e.mn);
        check({tag, ".max"},   longint'($signed(agg_max)), e.mx);
        check({tag, ".empty"}, agg_empty, e.empty);
        check({tag, ".sat"},   agg_sat, e.sat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends every beat of seg with up to gap_max idle (junk) cycles between
    // beats; returns in the cycle right after the last beat's edge.
    task automatic send_seg(input string tag, input int gap_max);
        foreach (seg[i]) begin
            int gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_mask = $urandom;
                in_last = $urandom;
                in_data = $urandom;
                step();
            end
            for (int w = 0; w < 20 && !in_ready; w++) step();
            if (!in_ready) begin
                n_fail++;
                $display("FAIL %s.ready_timeout: in_ready stuck at 0", tag);
            end
            in_valid = 1'b1;
            in_mask = seg[i].m;
            in_data = seg[i].d;
            in_last = (i == seg.size() - 1);
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check({tag, ".valid_lat"}, agg_valid, 1);
        check({tag, ".ready_low"}, in_ready, 0);
    endtask

    task automatic take_rec(input string tag, input int wait_max);
        int w = (wait_max > 0) ? $urandom_range(wait_max, 0) : 0;
        for (int i = 0; i < w; i++) step();
        check({tag, ".still_valid"}, agg_valid, 1);
        agg_ready = 1'b1;
        step();
        agg_ready = 1'b0;
        check({tag, ".valid_drop"}, agg_valid, 0);
        check({tag, ".ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        rec_t e;
        rec_t held;

        tbl[0] = '{4, '{1, 0, 1, 1}, '{5, 100, -3, 7},   4, 3,   9,  -3,   7, 1'b0};
        tbl[1] = '{3, '{0, 0, 0, 0}, '{9, -9, 1, 0},     3, 0,   0,   0,   0, 1'b1};
        tbl[2] = '{1, '{1, 0, 0, 0}, '{-8, 0, 0, 0},     1, 1,  -8,  -8,  -8, 1'b0};
        tbl[3] = '{2, '{0, 1, 0, 0}, '{50, -20, 0, 0},   2, 1, -20, -20, -20, 1'b0};

        // Reset state
        #12;
        check("rst.in_ready", in_ready, 1);
        check("rst.agg_valid", agg_valid, 0);
        e = '{0, 0, 0, 0, 0, 1'b1, 1'b0};
        check_rec("rst", e);
        step();
        reset = 1'b0;
        step();

        // Table-driven segments
        foreach (tbl[k]) begin
            seg.delete();
            for (int i = 0; i < tbl[k].n; i++) seg.push_back('{tbl[k].m[i], tbl[k].d[i]});
            send_seg($sformatf("tbl%0d", k), 0);
            e = '{tbl[k].rows, tbl[k].count, tbl[k].sum, tbl[k].mn, tbl[k].mx, tbl[k].empty, 1'b0};
            check_rec($sformatf("tbl%0d", k), e);
            take_rec($sformatf("tbl%0d", k), 0);
        end

        // Back-pressure: record held, inputs not consumed
        seg.delete();
        seg.push_back('{1'b1, 11});
        seg.push_back('{1'b1, -4});
        send_seg("hold", 0);
        held = model(65535);
        in_valid = 1'b1;
        in_mask = 1'b1;
        in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = $urandom;
            step();
            check("hold.in_ready", in_ready, 0);
            check("hold.valid", agg_valid, 1);
            check_rec("hold", held);
        end
        in_valid = 1'b0;
        take_rec("hold", 0);
        seg.delete();
        seg.push_back('{1'b1, 10});
        send_seg("after_hold", 0);
        check_rec("after_hold", model(65535));
        take_rec("after_hold", 0);

        // Back-to-back single-beat segments with agg_ready tied high
        agg_ready = 1'b1;
        in_valid = 1'b1;
        in_mask = 1'b1;
        in_last = 1'b1;
        in_data = 32'h7FFF_FFFF;
        step();
        check("b2b.v0", agg_valid, 1);
        check("b2b.sum0", longint'($signed(agg_sum)), 64'sd2147483647);
        in_data = 32'h8000_0000;
        step();
        check("b2b.v1", agg_valid, 0);
        check("b2b.r1", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("b2b.v2", agg_valid, 1);
        check("b2b.sum2", longint'($signed(agg_sum)), -64'sd2147483648);
        check("b2b.min2", longint'($signed(agg_min)), -64'sd2147483648);
        step();
        check("b2b.v3", agg_valid, 0);
        agg_ready = 1'b0;
        in_last = 1'b0;

        // Saturation with a 4-bit counter
        s_mask = 1'b1;
        s_data = 1;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_last = (i == 19);
            check("sat.ready", s_ready, 1);
            step();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        check("sat.valid", s_avalid, 1);
        check("sat.rows", s_rows, 15);
        check("sat.count", s_count, 15);
        check("sat.sum", longint'($signed(s_sum)), 15);
        check("sat.flag", s_sat, 1);
        s_aready = 1'b1;
        step();
        s_aready = 1'b0;
        s_valid = 1'b1;
        s_mask = 1'b1;
        s_data = 3;
        step();
        s_mask = 1'b0;
        s_last = 1'b1;
        step();
        s_valid = 1'b0;
        s_last = 1'b0;
        check("sat2.valid", s_avalid, 1);
        check("sat2.rows", s_rows, 2);
        check("sat2.count", s_count, 1);
        check("sat2.sum", longint'($signed(s_sum)), 3);
        check("sat2.flag", s_sat, 0);
        s_aready = 1'b1;
        step();
        s_aready = 1'b0;

        // Reset mid-segment discards the partial segment
        in_valid = 1'b1;
        in_mask = 1'b1;
        in_last = 1'b0;
        in_data = 1000;
        step();
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("rst_mid.in_ready", in_ready, 1);
        check("rst_mid.valid", agg_valid, 0);
        step();
        reset = 1'b0;
        step();
        seg.delete();
        seg.push_back('{1'b1, 42});
        send_seg("rst_mid", 0);
        e = '{1, 1, 42, 42, 42, 1'b0, 1'b0};
        check_rec("rst_mid", e);

        // Reset while holding a record
        reset = 1'b1;
        #2;
        check("rst_hold.valid", agg_valid, 0);
        check("rst_hold.rows", agg_rows, 0);
        check("rst_hold.empty", agg_empty, 1);
        step();
        reset = 1'b0;
        step();

        // Random segments against the reference model
        for (int s = 0; s < 40; s++) begin
            int len = $urandom_range(6, 1);
            seg.delete();
            for (int i = 0; i < len; i++) begin
                int d = $urandom;
                if ($urandom_range(3, 0) == 0) d = $urandom_range(8, 0) - 4;
                seg.push_back('{bit'($urandom_range(1, 0)), d});
            end
            send_seg($sformatf("rnd%0d", s), 2);
            check_rec($sformatf("rnd%0d", s), model(65535));
            take_rec($sformatf("rnd%0d", s), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
